// File: rtl/fc_alu_sequencer.sv
// fc_alu_sequencer
//
// Sequences one fully-connected ALU to compute a single output neuron over
// num_chunks chunks of INPUT_SZ lanes. For each chunk it fetches the value
// vector then the weight vector from a shared read port, loads them into the
// ALU and chains the ALU result back in as the next chunk's bias. The finished
// neuron value is returned over a valid/ready handshake.
//
// Optional feature (compile-time macro FC_SEQ_RELU_EN):
//   defined   : a negative result is replaced by 0 when it is presented on out_data
//   undefined : out_data carries the raw signed result
//   Partial-sum chaining inside the neuron is identical in both builds.
//
// Ports
//   clk, rst         clock (posedge) and synchronous active-high reset
//   start            begin a neuron (sampled only while idle)
//   num_chunks       chunk count N, latched at start
//   val_base         word address of value chunk 0, latched at start
//   wgt_base         word address of weight chunk 0, latched at start
//   bias             neuron bias, latched at start
//   busy             high whenever the sequencer is not idle
//   mem_rd_en        one-cycle read request
//   mem_addr         read word address
//   mem_rd_valid     read data valid (L >= 1 cycles after mem_rd_en)
//   mem_rd_data      read vector, lane i = bits [i*SIZE +: SIZE]
//   alu_values       registered vector to the ALU values input
//   alu_single       bias / partial sum to the ALU single input
//   alu_load_enable  0 = load values, 1 = load bias+weights, 2 = hold
//   alu_clear        ALU clear
//   alu_value        ALU result
//   out_valid        result valid
//   out_ready        consumer accepts result
//   out_data         neuron result
module fc_alu_sequencer #(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned PRECISION = 11,
  parameter int unsigned INPUT_SZ  = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_chunks,
  input  logic [ADDR_W-1:0]        val_base,
  input  logic [ADDR_W-1:0]        wgt_base,
  input  logic [SIZE-1:0]          bias,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_rd_valid,
  input  logic [INPUT_SZ*SIZE-1:0] mem_rd_data,
  output logic [INPUT_SZ*SIZE-1:0] alu_values,
  output logic [SIZE-1:0]          alu_single,
  output logic [1:0]               alu_load_enable,
  output logic                     alu_clear,
  input  logic [SIZE-1:0]          alu_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_data
);

  // The fixed-point format needs a sign bit above the fraction.
  if (PRECISION >= SIZE) begin : gen_bad_precision
    $error("PRECISION must be smaller than SIZE");
  end

  localparam logic [1:0] LeValues  = 2'd0;
  localparam logic [1:0] LeBiasWgt = 2'd1;
  localparam logic [1:0] LeHold    = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRdVal,
    StLdVal,
    StRdWgt,
    StLdWgt,
    StAcc,
    StOut
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]         k_q, k_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [ADDR_W-1:0]        val_base_q, val_base_d;
  logic [ADDR_W-1:0]        wgt_base_q, wgt_base_d;
  logic [SIZE-1:0]          bias_q, bias_d;
  logic [SIZE-1:0]          psum_q, psum_d;

  logic                     busy_q, busy_d;
  logic                     mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [INPUT_SZ*SIZE-1:0] alu_values_q, alu_values_d;
  logic [SIZE-1:0]          alu_single_q, alu_single_d;
  logic [1:0]               alu_load_enable_q, alu_load_enable_d;
  logic                     alu_clear_q, alu_clear_d;
  logic                     out_valid_q, out_valid_d;
  logic [SIZE-1:0]          out_data_q, out_data_d;

  logic                     rd_accept;
  logic                     enter;
  logic [SIZE-1:0]          raw_res;
  logic [SIZE-1:0]          relu_res;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    n_d          = n_q;
    val_base_d   = val_base_q;
    wgt_base_d   = wgt_base_q;
    bias_d       = bias_q;
    psum_d       = psum_q;
    alu_values_d = alu_values_q;

    // mem_rd_en_q is high exactly in the issue cycle of a read state, so a
    // valid seen alongside it cannot belong to this request.
    rd_accept = mem_rd_valid && !mem_rd_en_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d        = num_chunks;
          val_base_d = val_base;
          wgt_base_d = wgt_base;
          bias_d     = bias;
          k_d        = '0;
          state_d    = StClear;
        end
      end
      StClear: begin
        state_d = (n_q == '0) ? StOut : StRdVal;
      end
      StRdVal: begin
        if (rd_accept) begin
          alu_values_d = mem_rd_data;
          state_d      = StLdVal;
        end
      end
      StLdVal: begin
        state_d = StRdWgt;
      end
      StRdWgt: begin
        if (rd_accept) begin
          alu_values_d = mem_rd_data;
          state_d      = StLdWgt;
        end
      end
      StLdWgt: begin
        state_d = StAcc;
      end
      StAcc: begin
        psum_d = alu_value;
        if (k_q == (n_q - CNT_W'(1))) begin
          state_d = StOut;
        end else begin
          k_d     = k_q + CNT_W'(1);
          state_d = StRdVal;
        end
      end
      StOut: begin
        if (out_valid_q && out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    enter = (state_d != state_q);

    busy_d      = (state_d != StIdle);
    mem_rd_en_d = enter && ((state_d == StRdVal) || (state_d == StRdWgt));

    mem_addr_d = mem_addr_q;
    if (enter && (state_d == StRdVal)) begin
      mem_addr_d = val_base_d + ADDR_W'(k_d);
    end
    if (enter && (state_d == StRdWgt)) begin
      mem_addr_d = wgt_base_d + ADDR_W'(k_d);
    end

    alu_load_enable_d = LeHold;
    if (state_d == StLdVal) begin
      alu_load_enable_d = LeValues;
    end
    if (state_d == StLdWgt) begin
      alu_load_enable_d = LeBiasWgt;
    end

    alu_clear_d = (state_d == StClear);

    // Chunk 0 starts from the neuron bias; later chunks continue the partial sum.
    alu_single_d = alu_single_q;
    if (enter && (state_d == StLdWgt)) begin
      alu_single_d = (k_q == '0) ? bias_q : psum_q;
    end

    out_valid_d = (state_d == StOut);

    raw_res = (n_q == '0) ? bias_q : psum_d;
`ifdef FC_SEQ_RELU_EN
    relu_res = raw_res[SIZE-1] ? '0 : raw_res;
`else
    relu_res = raw_res;
`endif
    // Captured once on entry so the value stays put while the consumer stalls.
    out_data_d = out_data_q;
    if (enter && (state_d == StOut)) begin
      out_data_d = relu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      k_q               <= '0;
      n_q               <= '0;
      val_base_q        <= '0;
      wgt_base_q        <= '0;
      bias_q            <= '0;
      psum_q            <= '0;
      busy_q            <= 1'b0;
      mem_rd_en_q       <= 1'b0;
      mem_addr_q        <= '0;
      alu_values_q      <= '0;
      alu_single_q      <= '0;
      alu_load_enable_q <= LeHold;
      alu_clear_q       <= 1'b1;
      out_valid_q       <= 1'b0;
      out_data_q        <= '0;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      n_q               <= n_d;
      val_base_q        <= val_base_d;
      wgt_base_q        <= wgt_base_d;
      bias_q            <= bias_d;
      psum_q            <= psum_d;
      busy_q            <= busy_d;
      mem_rd_en_q       <= mem_rd_en_d;
      mem_addr_q        <= mem_addr_d;
      alu_values_q      <= alu_values_d;
      alu_single_q      <= alu_single_d;
      alu_load_enable_q <= alu_load_enable_d;
      alu_clear_q       <= alu_clear_d;
      out_valid_q       <= out_valid_d;
      out_data_q        <= out_data_d;
    end
  end

  assign busy            = busy_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_addr        = mem_addr_q;
  assign alu_values      = alu_values_q;
  assign alu_single      = alu_single_q;
  assign alu_load_enable = alu_load_enable_q;
  assign alu_clear       = alu_clear_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;

endmodule

// File: tb/tb_fc_alu_sequencer.sv
// Testbench for fc_alu_sequencer: memory and ALU behaviour are emulated here,
// expected neuron values come from a chunk-by-chunk fixed-point reference.
module tb_fc_alu_sequencer;

  localparam int SIZE      = 16;
  localparam int PRECISION = 11;
  localparam int INPUT_SZ  = 4;
  localparam int ADDR_W    = 12;
  localparam int CNT_W     = 8;
  localparam int W         = INPUT_SZ * SIZE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_chunks = '0;
  logic [ADDR_W-1:0] val_base = '0;
  logic [ADDR_W-1:0] wgt_base = '0;
  logic [SIZE-1:0]   bias = '0;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid = 1'b0;
  logic [W-1:0]      mem_rd_data = '0;
  logic [W-1:0]      alu_values;
  logic [SIZE-1:0]   alu_single;
  logic [1:0]        alu_load_enable;
  logic              alu_clear;
  logic [SIZE-1:0]   alu_value;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SIZE-1:0]   out_data;

  fc_alu_sequencer #(
    .SIZE      (SIZE),
    .PRECISION (PRECISION),
    .INPUT_SZ  (INPUT_SZ),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_chunks      (num_chunks),
    .val_base        (val_base),
    .wgt_base        (wgt_base),
    .bias            (bias),
    .busy            (busy),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .alu_values      (alu_values),
    .alu_single      (alu_single),
    .alu_load_enable (alu_load_enable),
    .alu_clear       (alu_clear),
    .alu_value       (alu_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail(input string nm, input string detail);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s (t=%0t)", nm, detail, $time);
  endfunction

  // One chunk of a neuron: s + sum_i (v_i * w_i) in Q(SIZE-PRECISION).PRECISION,
  // each product truncated to the fixed-point grid, result wrapped to SIZE bits.
  function automatic logic [SIZE-1:0] fx_dot(input logic [SIZE-1:0] s, input logic [W-1:0] v,
                                             input logic [W-1:0] w);
    int acc;
    int a;
    int b;
    acc = int'($signed(s));
    for (int i = 0; i < INPUT_SZ; i++) begin
      a = int'($signed(v[i*SIZE +: SIZE]));
      b = int'($signed(w[i*SIZE +: SIZE]));
      acc += (a * b) >>> PRECISION;
    end
    return acc[SIZE-1:0];
  endfunction

  // ALU emulation: registers captured on negedge, result combinational.
  logic [W-1:0]    alu_vals_r = '0;
  logic [W-1:0]    alu_wgts_r = '0;
  logic [SIZE-1:0] alu_single_r = '0;
  always @(negedge clk) begin
    if (alu_clear) begin
      alu_vals_r   = '0;
      alu_wgts_r   = '0;
      alu_single_r = '0;
    end else if (alu_load_enable == 2'd0) begin
      alu_vals_r = alu_values;
    end else if (alu_load_enable == 2'd1) begin
      alu_single_r = alu_single;
      alu_wgts_r   = alu_values;
    end
  end
  assign alu_value = fx_dot(alu_single_r, alu_vals_r, alu_wgts_r);

  // Memory emulation with programmable latency and optional junk valid pulses
  // (only where the sequencer is not waiting for a response).
  logic [W-1:0]      mem [0:(1<<ADDR_W)-1];
  int                lat = 1;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  int                req_cnt = 0;
  bit                noise_en = 0;
  always @(negedge clk) begin
    bit delivered;
    delivered    = 0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = {$urandom, $urandom};
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[pend_addr];
        delivered    = 1;
      end
    end
    if (!delivered && pend_cnt == 0 && noise_en && $urandom_range(0, 2) == 0) begin
      mem_rd_valid = 1'b1;
    end
    if (mem_rd_en) begin
      pend_cnt  = lat;
      pend_addr = mem_addr;
      req_cnt++;
      if (noise_en) mem_rd_valid = 1'b1;  // junk in the issue cycle
    end
  end

  // Reference model: fold the chunks straight out of the memory image.
  function automatic logic [SIZE-1:0] ref_neuron(input int n, input logic [ADDR_W-1:0] vb,
                                                 input logic [ADDR_W-1:0] wb,
                                                 input logic [SIZE-1:0] b);
    logic [SIZE-1:0]   s;
    logic [ADDR_W-1:0] va;
    logic [ADDR_W-1:0] wa;
    s = b;
    for (int k = 0; k < n; k++) begin
      va = vb + ADDR_W'(k);
      wa = wb + ADDR_W'(k);
      s  = fx_dot(s, mem[va], mem[wa]);
    end
`ifdef FC_SEQ_RELU_EN
    if (s[SIZE-1]) s = '0;
`endif
    return s;
  endfunction

  typedef struct {
    logic [SIZE-1:0] data;
    int              lat;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                start_cyc = 0;
  int                done_cnt = 0;
  int                stall_left = 0;
  bit                rand_ready = 0;

  // Monitor / scoreboard
  logic            prev_valid = 1'b0;
  logic            prev_ready = 1'b1;
  logic [SIZE-1:0] prev_data = '0;
  exp_t            mon_e;
  logic [ADDR_W-1:0] mon_a;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          fail("unexpected_read", $sformatf("read of %0h, expected no read", mem_addr));
        end else begin
          mon_a = addr_q.pop_front();
          check("rd_addr", 64'(mem_addr), 64'(mon_a));
        end
      end

      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_result", $sformatf("out_valid with data %0h, expected none", out_data));
        end else begin
          check("latency", 64'(cyc - start_cyc), 64'(exp_q[0].lat));
        end
      end

      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(out_valid), 64'(1'b1));
        check("hold_data", 64'(out_data), 64'(prev_data));
      end

      if (out_valid && out_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        done_cnt++;
      end

      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'(1'b0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_alu_values", 64'(alu_values), 64'(0));
    check("rst_alu_single", 64'(alu_single), 64'(0));
    check("rst_alu_load_enable", 64'(alu_load_enable), 64'(2));
    check("rst_alu_clear", 64'(alu_clear), 64'(1'b1));
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_data", 64'(out_data), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stall_left = 0;
    tick();
    tick();
    check_reset_vals();
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    tick();
  endtask

  task automatic run_job(input int n, input logic [ADDR_W-1:0] vb, input logic [ADDR_W-1:0] wb,
                         input logic [SIZE-1:0] b, input int l, input bit use_c,
                         input logic [SIZE-1:0] cexp, input bit spam);
    exp_t e;
    int   target;
    int   bound;
    int   waited;
    lat = l;
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(vb + ADDR_W'(k));
      addr_q.push_back(wb + ADDR_W'(k));
    end
    e.data = use_c ? cexp : ref_neuron(n, vb, wb, b);
    e.lat  = 1 + n * (5 + 2 * l);
    exp_q.push_back(e);
    check("idle_busy", 64'(busy), 64'(1'b0));
    num_chunks = CNT_W'(n);
    val_base   = vb;
    wgt_base   = wb;
    bias       = b;
    start      = 1'b1;
    start_cyc  = cyc + 1;
    target     = done_cnt + 1;
    tick();
    start      = 1'b0;
    num_chunks = CNT_W'($urandom);
    val_base   = ADDR_W'($urandom);
    wgt_base   = ADDR_W'($urandom);
    bias       = SIZE'($urandom);
    check("busy_after_start", 64'(busy), 64'(1'b1));
    check("clear_pulse", 64'(alu_clear), 64'(1'b1));
    bound  = e.lat + 200;
    waited = 0;
    while (done_cnt < target && waited < bound) begin
      tick();
      waited++;
      start = (spam && done_cnt < target) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (start) num_chunks = CNT_W'($urandom_range(0, 3));
    end
    start = 1'b0;
    if (done_cnt < target) begin
      fail("job_timeout", $sformatf("no result after %0d cycles, expected within %0d", waited, bound));
      do_reset();
    end else begin
      tick();
    end
  endtask

  task automatic fill_chunk(input logic [ADDR_W-1:0] a, input logic [SIZE-1:0] lane);
    mem[a] = {INPUT_SZ{lane}};
  endtask

  initial begin
    int r0;
    int waited;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom};

    do_reset();
    tick();
    check("idle_clear", 64'(alu_clear), 64'(1'b0));
    check("idle_load_enable", 64'(alu_load_enable), 64'(2));

    // Single chunk: 1.0 + 4 * (1.0 * 1.0) = 5.0
    fill_chunk(12'h010, 16'h0800);
    fill_chunk(12'h020, 16'h0800);
    run_job(1, 12'h010, 12'h020, 16'h0800, 1, 1, 16'h2800, 0);

    // Two chunks chained: 5.0 + 4.0 = 9.0
    fill_chunk(12'h100, 16'h0800);
    fill_chunk(12'h101, 16'h0800);
    fill_chunk(12'h200, 16'h0800);
    fill_chunk(12'h201, 16'h0800);
    run_job(2, 12'h100, 12'h200, 16'h0800, 1, 1, 16'h4800, 0);

    // Zero chunks: bias straight through, no reads
    run_job(0, 12'h300, 12'h400, 16'h1234, 1, 1, 16'h1234, 0);

    // Negative result
    fill_chunk(12'h030, 16'h0800);
    fill_chunk(12'h040, 16'h0000);
`ifdef FC_SEQ_RELU_EN
    run_job(1, 12'h030, 12'h040, 16'hF800, 1, 1, 16'h0000, 0);
`else
    run_job(1, 12'h030, 12'h040, 16'hF800, 1, 1, 16'hF800, 0);
`endif

    // Consumer stalls 5 cycles while start is hammered
    stall_left = 5;
    run_job(1, 12'h010, 12'h020, 16'h0800, 1, 1, 16'h2800, 1);

    // Address wrap-around at the top of the address space
    run_job(2, 12'hFFF, 12'hFFE, 16'h0100, 2, 0, 16'h0000, 0);

    // Abort in RD_WGT; the outstanding response arrives after reset
    lat = 3;
    r0 = req_cnt;
    addr_q.push_back(12'h050);
    addr_q.push_back(12'h060);
    num_chunks = 8'd2;
    val_base   = 12'h050;
    wgt_base   = 12'h060;
    bias       = 16'h0800;
    start      = 1'b1;
    tick();
    start  = 1'b0;
    waited = 0;
    while (req_cnt < r0 + 2 && waited < 50) begin
      tick();
      waited++;
    end
    if (req_cnt < r0 + 2) fail("abort_setup", $sformatf("%0d reads seen, expected 2", req_cnt - r0));
    rst = 1'b1;
    tick();
    check_reset_vals();
    rst = 1'b0;
    addr_q.delete();
    exp_q.delete();
    repeat (8) tick();
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_out_valid", 64'(out_valid), 64'(1'b0));
    check("abort_load_enable", 64'(alu_load_enable), 64'(2));
    check("abort_clear", 64'(alu_clear), 64'(1'b0));

    // Maximum chunk count
    run_job(255, 12'h400, 12'h800, 16'h0000, 1, 0, 16'h0000, 0);

    // Randomised jobs
    for (int t = 0; t < 40; t++) begin
      noise_en   = 1'($urandom_range(0, 1));
      rand_ready = 1'($urandom_range(0, 1));
      stall_left = $urandom_range(0, 3);
      run_job($urandom_range(0, 6), ADDR_W'($urandom), ADDR_W'($urandom), SIZE'($urandom),
              $urandom_range(1, 3), 0, 16'h0000, 1'($urandom_range(0, 1)));
    end
    noise_en   = 0;
    rand_ready = 0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
